// File: rtl/mmc_pkg.sv
// Shared types and constants for the match tracker: who codes, event record types,
// tracker FSM states and the packed 8-bit event record.
package mmc_pkg;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_LOSER  = 2'b01;
    localparam logic [1:0] WHO_WINNER = 2'b10;

    localparam logic [1:0] EVT_GAME  = 2'b01;
    localparam logic [1:0] EVT_MATCH = 2'b10;
    localparam logic [1:0] EVT_ERROR = 2'b11;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'b00,
        ST_MATCH_LOG = 2'b01,
        ST_DONE      = 2'b10
    } mmc_trk_state_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] who;
        logic [3:0] score;
    } mmc_evt_t;

    function automatic mmc_evt_t mk_evt(input logic [1:0] kind,
                                        input logic [1:0] who,
                                        input logic [3:0] score);
        mmc_evt_t e;
        e.kind  = kind;
        e.who   = who;
        e.score = score;
        return e;
    endfunction

endpackage

// File: rtl/mmc_evt_fifo.sv
// Synchronous event FIFO with drop-on-full and a sticky overflow flag.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module mmc_evt_fifo
    import mmc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/mmc_match_tracker.sv
// Best-of-N match tracker: edge-detects the game block's outputs, keeps game scores
// and a per-game round count, and reports GAME/MATCH/ERROR records through a FIFO.
module mmc_match_tracker
    import mmc_pkg::*;
#(
    parameter int GAMES_TO_WIN = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       winner,
    input  logic       loser,
    input  logic       gameover,
    input  logic [1:0] who,
    input  logic       new_match,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_data,
    output logic [3:0] score_w,
    output logic [3:0] score_l,
    output logic [7:0] rounds,
    output logic       match_over,
    output logic [1:0] match_who,
    output logic       evt_overflow
);

    localparam logic [3:0] L_TARGET = 4'(GAMES_TO_WIN);

    mmc_trk_state_t r_state;
    mmc_trk_state_t w_state_next;

    logic       r_winner_q;
    logic       r_loser_q;
    logic       r_gameover_q;
    logic [3:0] r_score_w;
    logic [3:0] r_score_l;
    logic [7:0] r_rounds;
    logic       r_match_over;
    logic [1:0] r_match_who;
    logic       r_nm_pending;

    logic       w_win_rise;
    logic       w_los_rise;
    logic       w_go_rise;
    logic       w_restart;
    logic [3:0] w_score_w_inc;
    logic [3:0] w_score_l_inc;
    logic [1:0] w_match_side;
    logic [3:0] w_match_score;
    logic [8:0] w_rounds_sum;
    logic [7:0] w_rounds_sat;

    logic       w_push;
    mmc_evt_t   w_push_data;
    logic       w_inc_w;
    logic       w_inc_l;
    logic       w_clear_all;
    logic       w_clear_rounds;
    logic       w_set_match;
    logic       w_defer_nm;

    assign w_win_rise    = winner   && !r_winner_q;
    assign w_los_rise    = loser    && !r_loser_q;
    assign w_go_rise     = gameover && !r_gameover_q;
    assign w_score_w_inc = r_score_w + 4'd1;
    assign w_score_l_inc = r_score_l + 4'd1;

    // A new_match seen during MATCH_LOG is parked in r_nm_pending and acts one cycle later.
    assign w_restart = r_nm_pending || (new_match && (r_state != ST_MATCH_LOG));

    assign w_match_side  = (r_score_w == L_TARGET) ? WHO_WINNER : WHO_LOSER;
    assign w_match_score = (r_score_w == L_TARGET) ? r_score_w : r_score_l;

    assign w_rounds_sum = {1'b0, r_rounds} + 9'(w_win_rise) + 9'(w_los_rise);
    assign w_rounds_sat = w_rounds_sum[8] ? 8'hFF : w_rounds_sum[7:0];

    always_comb begin
        w_state_next   = r_state;
        w_push         = 1'b0;
        w_push_data    = mk_evt(2'b00, WHO_NONE, 4'd0);
        w_inc_w        = 1'b0;
        w_inc_l        = 1'b0;
        w_clear_all    = 1'b0;
        w_clear_rounds = 1'b0;
        w_set_match    = 1'b0;
        w_defer_nm     = 1'b0;

        case (r_state)
            ST_PLAY: begin
                if (w_restart) begin
                    w_clear_all = 1'b1;
                end else if (w_go_rise) begin
                    if (who == WHO_WINNER) begin
                        w_inc_w        = 1'b1;
                        w_clear_rounds = 1'b1;
                        w_push         = 1'b1;
                        w_push_data    = mk_evt(EVT_GAME, WHO_WINNER, w_score_w_inc);
                        if (w_score_w_inc == L_TARGET) begin
                            w_state_next = ST_MATCH_LOG;
                        end
                    end else if (who == WHO_LOSER) begin
                        w_inc_l        = 1'b1;
                        w_clear_rounds = 1'b1;
                        w_push         = 1'b1;
                        w_push_data    = mk_evt(EVT_GAME, WHO_LOSER, w_score_l_inc);
                        if (w_score_l_inc == L_TARGET) begin
                            w_state_next = ST_MATCH_LOG;
                        end
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = mk_evt(EVT_ERROR, who, 4'd0);
                    end
                end
            end
            ST_MATCH_LOG: begin
                w_push       = 1'b1;
                w_push_data  = mk_evt(EVT_MATCH, w_match_side, w_match_score);
                w_set_match  = 1'b1;
                w_defer_nm   = new_match;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_restart) begin
                    w_clear_all  = 1'b1;
                    w_state_next = ST_PLAY;
                end
            end
            default: begin
                w_state_next = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A game clear or match restart takes priority over round edges in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_winner_q   <= 1'b0;
            r_loser_q    <= 1'b0;
            r_gameover_q <= 1'b0;
            r_score_w    <= 4'd0;
            r_score_l    <= 4'd0;
            r_rounds     <= 8'd0;
            r_match_over <= 1'b0;
            r_match_who  <= WHO_NONE;
            r_nm_pending <= 1'b0;
        end else begin
            r_winner_q   <= winner;
            r_loser_q    <= loser;
            r_gameover_q <= gameover;
            if (w_clear_all) begin
                r_score_w    <= 4'd0;
                r_score_l    <= 4'd0;
                r_rounds     <= 8'd0;
                r_match_over <= 1'b0;
                r_match_who  <= WHO_NONE;
                r_nm_pending <= 1'b0;
            end else begin
                if (w_inc_w) begin
                    r_score_w <= w_score_w_inc;
                end
                if (w_inc_l) begin
                    r_score_l <= w_score_l_inc;
                end
                if (w_set_match) begin
                    r_match_over <= 1'b1;
                    r_match_who  <= w_match_side;
                end
                if (w_defer_nm) begin
                    r_nm_pending <= 1'b1;
                end
                r_rounds <= w_clear_rounds ? 8'd0 : w_rounds_sat;
            end
        end
    end

    mmc_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_evt_fifo (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_push     (w_push),
        .i_data     (w_push_data),
        .i_pop      (evt_ready),
        .o_valid    (evt_valid),
        .o_data     (evt_data),
        .o_overflow (evt_overflow)
    );

    assign score_w    = r_score_w;
    assign score_l    = r_score_l;
    assign rounds     = r_rounds;
    assign match_over = r_match_over;
    assign match_who  = r_match_who;

endmodule

// File: tb/tb_mmc_match_tracker.sv
// Scoreboard bench for mmc_match_tracker: directed scenarios plus random traffic,
// checked against a behavioural match model and an expected-event queue.
module tb_mmc_match_tracker;

    localparam int G = 3;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       winner = 1'b0;
    logic       loser = 1'b0;
    logic       gameover = 1'b0;
    logic [1:0] who = 2'b00;
    logic       new_match = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic [3:0] score_w;
    logic [3:0] score_l;
    logic [7:0] rounds;
    logic       match_over;
    logic [1:0] match_who;
    logic       evt_overflow;

    always #5 clk = ~clk;

    mmc_match_tracker #(
        .GAMES_TO_WIN (G),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .winner       (winner),
        .loser        (loser),
        .gameover     (gameover),
        .who          (who),
        .new_match    (new_match),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .score_w      (score_w),
        .score_l      (score_l),
        .rounds       (rounds),
        .match_over   (match_over),
        .match_who    (match_who),
        .evt_overflow (evt_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: match progress as plain integers and flags.
    int         m_sw, m_sl, m_rounds, m_count;
    bit         m_over, m_log_pending, m_deferred, m_ovf;
    logic [1:0] m_who;
    bit         m_pw, m_pl, m_pg;
    bit         started = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin : model
        bit         wr, lr, gr, pop, have;
        int         c, sc;
        logic [1:0] side;
        logic [7:0] rec;
        if (!rst_n) begin
            m_sw = 0; m_sl = 0; m_rounds = 0; m_count = 0;
            m_over = 0; m_log_pending = 0; m_deferred = 0; m_ovf = 0;
            m_who = 2'b00; m_pw = 0; m_pl = 0; m_pg = 0;
            exp_q.delete();
            started = 1'b1;
        end else begin
            wr   = winner && !m_pw;
            lr   = loser && !m_pl;
            gr   = gameover && !m_pg;
            pop  = (m_count > 0) && evt_ready;
            have = 1'b0;
            rec  = 8'h00;
            if (m_log_pending) begin
                side = (m_sw == G) ? 2'b10 : 2'b01;
                sc   = (m_sw == G) ? m_sw : m_sl;
                rec  = {2'b10, side, 4'(sc)};
                have = 1'b1;
                m_over = 1'b1;
                m_who  = side;
                m_log_pending = 1'b0;
                if (new_match) m_deferred = 1'b1;
                m_rounds = (m_rounds + wr + lr > 255) ? 255 : m_rounds + wr + lr;
            end else if (new_match || m_deferred) begin
                m_sw = 0; m_sl = 0; m_rounds = 0;
                m_over = 0; m_who = 2'b00; m_deferred = 0;
            end else if (!m_over && gr && (who == 2'b10 || who == 2'b01)) begin
                if (who == 2'b10) begin m_sw++; sc = m_sw; end
                else              begin m_sl++; sc = m_sl; end
                rec  = {2'b01, who, 4'(sc)};
                have = 1'b1;
                m_rounds = 0;
                if (sc == G) m_log_pending = 1'b1;
            end else begin
                if (!m_over && gr) begin
                    rec  = {2'b11, who, 4'h0};
                    have = 1'b1;
                end
                m_rounds = (m_rounds + wr + lr > 255) ? 255 : m_rounds + wr + lr;
            end
            c = m_count;
            if (pop) c--;
            if (have) begin
                if (m_count == D && !pop) begin
                    m_ovf = 1'b1;
                end else begin
                    c++;
                    exp_q.push_back(rec);
                end
            end
            m_count = c;
            m_pw = winner; m_pl = loser; m_pg = gameover;
        end
    end

    // Monitor: every handshake pops the scoreboard; state outputs are checked each cycle.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("score_w", 32'(score_w), 32'(m_sw));
            checkOutput("score_l", 32'(score_l), 32'(m_sl));
            checkOutput("rounds", 32'(rounds), 32'(m_rounds));
            checkOutput("match_over", 32'(match_over), 32'(m_over));
            checkOutput("match_who", 32'(match_who), 32'(m_who));
            checkOutput("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
            checkOutput("evt_valid", 32'(evt_valid), 32'(m_count > 0));
            if (!evt_valid) begin
                checkOutput("evt_data_idle", 32'(evt_data), 32'h0);
            end
            if (rst_n && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL evt_unexpected: got %0h, expected no event", evt_data);
                end else begin
                    checkOutput("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic l, input logic g,
                                 input logic [1:0] wh, input logic nm,
                                 input logic rdy, input logic rst);
        @(posedge clk);
        #2;
        winner = w; loser = l; gameover = g; who = wh;
        new_match = nm; evt_ready = rdy; rst_n = rst;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 2'b00, 0, rdy, 1);
    endtask

    task automatic playGame(input logic [1:0] wh, input logic rdy);
        applyStimulus(0, 0, 1, wh, 0, rdy, 1);
        applyStimulus(0, 0, 0, wh, 0, rdy, 1);
    endtask

    task automatic newMatch(input logic rdy);
        applyStimulus(0, 0, 0, 2'b00, 1, rdy, 1);
        applyStimulus(0, 0, 0, 2'b00, 0, rdy, 1);
    endtask

    initial begin
        logic w, l, g, nm, rdy, rst;
        logic [1:0] wh;
        int r;

        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
        checkOutput("reset_score_w", 32'(score_w), 0);
        checkOutput("reset_evt_valid", 32'(evt_valid), 0);
        checkOutput("reset_evt_data", 32'(evt_data), 0);

        applyStimulus(1, 0, 0, 2'b00, 0, 1, 1);
        playGame(2'b10, 1);
        checkOutput("first_game_score_w", 32'(score_w), 1);
        checkOutput("first_game_rounds", 32'(rounds), 0);
        idle(2, 1);

        newMatch(1);
        for (int i = 0; i < 3; i++) playGame(2'b01, 1);
        idle(1, 1);
        checkOutput("match_score_l", 32'(score_l), 3);
        checkOutput("match_over_set", 32'(match_over), 1);
        checkOutput("match_who_loser", 32'(match_who), 32'(2'b01));
        playGame(2'b01, 1);
        idle(2, 1);
        checkOutput("done_ignores_game", 32'(score_l), 3);

        newMatch(1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 2'b10, 0, 1, 1);
        applyStimulus(0, 0, 0, 2'b10, 0, 1, 1);
        checkOutput("level_held_once", 32'(score_w), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 2'b00, 0, 1, 1);
            applyStimulus(0, 0, 0, 2'b00, 0, 1, 1);
        end
        idle(1, 1);
        checkOutput("winner_toggles", 32'(rounds), 4);

        newMatch(1);
        idle(3, 1);
        playGame(2'b10, 0); playGame(2'b01, 0); playGame(2'b10, 0);
        playGame(2'b01, 0); playGame(2'b10, 0);
        idle(2, 0);
        checkOutput("overflow_set", 32'(evt_overflow), 1);
        newMatch(1);
        idle(8, 1);
        playGame(2'b11, 1);
        playGame(2'b00, 1);
        checkOutput("error_keeps_scores", 32'({score_w, score_l}), 0);
        idle(4, 1);

        applyStimulus(0, 0, 1, 2'b10, 1, 1, 1);
        applyStimulus(0, 0, 0, 2'b10, 0, 1, 1);
        idle(1, 1);
        checkOutput("nm_wins_score", 32'(score_w), 0);
        checkOutput("nm_wins_no_evt", 32'(evt_valid), 0);

        playGame(2'b10, 1); playGame(2'b10, 1);
        applyStimulus(0, 0, 1, 2'b10, 0, 1, 1);
        applyStimulus(0, 0, 0, 2'b00, 0, 1, 0);
        applyStimulus(0, 0, 0, 2'b00, 0, 1, 1);
        checkOutput("reset_in_log_over", 32'(match_over), 0);
        checkOutput("reset_in_log_score", 32'(score_w), 0);
        checkOutput("reset_in_log_valid", 32'(evt_valid), 0);

        w = 0; l = 0; g = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) w = ~w;
            if ($urandom_range(0, 2) == 0) l = ~l;
            if ($urandom_range(0, 2) == 0) g = ~g;
            r = $urandom_range(0, 9);
            wh  = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01;
            nm  = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) != 0);
            applyStimulus(w, l, g, wh, nm, rdy, rst);
        end

        idle(20, 1);
        checkOutput("drain_empty", 32'(evt_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmc_match_tracker.md
# mmc_match_tracker

Downstream consumer of the multi-mode counter game block. Watches that block's `winner`, `loser`, `gameover` and `who` outputs and turns individual games into a best-of-N match. Keeps per-side game scores and a per-game round counter. Emits game, match and error records through a small valid/ready event FIFO to the display/host side.

## Interface
Parameters:
- `GAMES_TO_WIN`, default 3: games one side must take to win the match; legal range 1..15.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `winner`  in  1  round-winner level from the game block.
- `loser`  in  1  round-loser level from the game block.
- `gameover`  in  1  game-end level from the game block.
- `who`  in  2  game result code: 2'b10 = winner side, 2'b01 = loser side.
- `new_match`  in  1  one-cycle pulse; clears scores and restarts the match.
- `evt_ready`  in  1  sink accepts the head event.
- `evt_valid`  out  1  FIFO not empty.
- `evt_data`  out  8  head event record.
- `score_w`  out  4  games won by the winner side.
- `score_l`  out  4  games won by the loser side.
- `rounds`  out  8  round-win/round-loss edges seen in the current game; saturates at 255.
- `match_over`  out  1  high once the match is decided, until `new_match` or reset.
- `match_who`  out  2  match result code in `who` encoding; 2'b00 while the match is undecided.
- `evt_overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- **Edge detection.** Registered copies of `winner`, `loser` and `gameover` are kept. Only rising edges count. A level that stays high never re-counts.
- **Round counting.** Each rising edge of `winner`, and each rising edge of `loser`, adds 1 to `rounds`. If both rise in the same cycle, add 2. `rounds` saturates at 255.
- **Event record layout.** `evt_data` = {type[1:0], who[1:0], score[3:0]}.
  - type 2'b01 = GAME, 2'b10 = MATCH, 2'b11 = ERROR.
  - The score field holds the new game total of the side named in the who field.
  - ERROR records carry the offending `who` value with the score field set to 0.
- **FSM states: PLAY, MATCH_LOG, DONE.**
- **PLAY, on a `gameover` rising edge:**
  - If `who` is 2'b10 or 2'b01: increment the matching score, push a GAME record, and clear `rounds`.
  - If the new score equals `GAMES_TO_WIN`, go to MATCH_LOG; otherwise stay in PLAY.
  - If `who` is 2'b00 or 2'b11: push an ERROR record; scores and `rounds` are unchanged.
- **MATCH_LOG** (exactly one cycle): push a MATCH record with the winning side's score, set `match_over`, set `match_who`, then go to DONE.
- **DONE:** `gameover` edges are ignored; `rounds` still counts.
- **`new_match`:** accepted in PLAY or DONE.
  - Clears both scores, `rounds`, `match_over` and `match_who`; the next state is PLAY.
  - FIFO contents and `evt_overflow` are kept.
  - In MATCH_LOG, `new_match` is deferred: it is registered and applied in the following cycle.
- **`new_match` coinciding with a `gameover` edge in PLAY:** `new_match` wins and the game is discarded; no record is pushed.
- **FIFO behaviour:**
  - A pop happens when `evt_valid && evt_ready`.
  - A push while full drops the new record and sets `evt_overflow`.
  - A push and a pop in the same cycle while full both succeed; no drop occurs.
  - `evt_data` is valid whenever `evt_valid` is high and is held stable until popped.

## Timing
- **Reset** (`rst_n` low at a rising edge) forces:
  - state = PLAY;
  - `score_w` = 0, `score_l` = 0, `rounds` = 0;
  - `match_over` = 0, `match_who` = 2'b00;
  - FIFO empty, so `evt_valid` = 0 and `evt_data` = 8'h00;
  - `evt_overflow` = 0;
  - edge registers = 0.
- **Reset mid-operation** drops all queued events.
- **Score latency:** a `gameover` rising edge at edge *t* (`gameover`=1, previous=0) gives updated scores visible after edge *t*.
- **Event latency:** the GAME record is visible on `evt_valid`/`evt_data` after edge *t* if the FIFO was empty.
- **Deciding game:** MATCH_LOG occupies edge *t*+1. `match_over`/`match_who` and the MATCH record (queued behind the GAME record) appear after edge *t*+1.
- **Round latency:** `rounds` updates one cycle after the input rising edge.
- **Handshake:** no combinational path from `evt_ready` to `evt_valid` or `evt_data`.

## Structure
- Shared package `mmc_pkg`:
  - who codes (`WHO_WINNER` = 2'b10, `WHO_LOSER` = 2'b01);
  - event type constants;
  - the FSM state enum `mmc_trk_state_t`;
  - a packed struct `mmc_evt_t` for the 8-bit record.
- Sub-module `mmc_evt_fifo`: parameterised synchronous FIFO (depth, width) with push/pop, full/empty and a drop-on-full overflow flag. The tracker instantiates it once.

## Test plan
- **Reset defaults:** `rst_n` low for 2 cycles, then high -> all outputs zero, `evt_valid`=0.
- **Normal GAME event:** `gameover` pulse with `who`=2'b10, `evt_ready`=1 -> `score_w`=1; one event 8'h61 popped; `rounds` cleared.
- **Match decided:** `GAMES_TO_WIN`=3; three `gameover` edges with `who`=2'b01 -> `score_l`=3, `match_over`=1, `match_who`=2'b01.
  - Events in order: 8'h51, 8'h52, 8'h53, 8'h93.
  - A further `gameover` in DONE -> no change.
- **Level held:** `gameover` held high for 5 cycles -> exactly one score increment.
  - `winner` toggled 4 times -> `rounds`=4.
- **Overflow and error records:** `evt_ready`=0; 5 games with `FIFO_DEPTH`=4 -> 4 entries kept, `evt_overflow`=1.
  - `who`=2'b11 at a `gameover` edge -> ERROR record 8'hF0, scores unchanged.
- **Simultaneous events:** `new_match` coinciding with a `gameover` edge -> scores 0, no record pushed.
  - Reset asserted in MATCH_LOG -> all outputs at reset values on the next cycle.
